pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central sequencing controller for the fetch/decode/execute pipeline.
- Generates enable_fetch, enable_decode and enable_execute. enable_decode drives the decode stage's enable_decode input.
- Brings the pipeline up from idle in stages (warm-up).
- Detects load-use hazards and multiply/divide result hazards from the decode stage's registered fields, and stalls with execute bubbles.
- Tracks HI/LO busy time for the multi-cycle mult/div unit.

Parameters:
MULT_LAT, 4, cycles HI/LO stay busy after MULT/MULTU issues (1..2^CNT_W-1)
DIV_LAT, 32, cycles HI/LO stay busy after DIV/DIVU issues (1..2^CNT_W-1)
CNT_W, 6, width of the busy counter

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
run  in  1  1 = pipeline running; 0 = return to idle
dec_valid  in  1  decode-stage fields hold a real instruction
dec_opcode  in  6  decoded opcode (insn[31:26])
dec_rs  in  5  decoded rs
dec_rt  in  5  decoded rt
dec_func  in  6  decoded func (valid for opcode 000000)
enable_fetch  out  1  advance fetch / PC
enable_decode  out  1  load decode registers
enable_execute  out  1  execute stage accepts an instruction this cycle
bubble  out  1  execute receives a NOP instead of the decode instruction
issue  out  1  decode instruction advances into execute this cycle
stall_load  out  1  load-use stall active this cycle
stall_md  out  1  mult/div stall active this cycle
md_busy  out  1  HI/LO result pending (md_count != 0)

Behaviour:
- The interface is fixed: one clock, named clock; reset is synchronous and active-high, named reset.
- State register with states IDLE, FILL1, FILL2, RUN. Outputs are combinational from state, registers and dec_* inputs.
- Reset: state=IDLE, md_count=0, ex_load_valid=0, ex_load_rt=0. All outputs 0 during and after reset until run.
- Reset has priority over everything; reset mid-stall or mid-divide clears all state the same cycle.
- IDLE: all outputs 0. run=1 -> FILL1.
- FILL1: enable_fetch=1 only. -> FILL2.
- FILL2: enable_fetch=1, enable_decode=1. -> RUN.
- run=0 in any non-IDLE state: next state IDLE; outputs of that cycle are still the state's normal outputs.
- RUN, hazard terms:
  - uses_rs = dec_rs != 0, except R-type SLL/SRL/SRA (func 000000/000010/000011), MFHI/MFLO, J (000010), JAL (000011), LUI (001111).
  - uses_rt = dec_rt != 0, for R-type (except MFHI/MFLO/JR/JALR), SW (101011), SB (101000), BEQ (000100), BNE (000101).
  - stall_load = dec_valid & ex_load_valid & ((uses_rs & dec_rs==ex_load_rt) | (uses_rt & dec_rt==ex_load_rt)).
  - is_md = R-type with func 011000/011001/011010/011011. is_hilo = R-type MFHI (010000) / MFLO (010010).
  - stall_md = dec_valid & md_busy & (is_hilo | is_md).
- RUN, outputs:
  - stall = stall_load | stall_md.
  - enable_fetch = enable_decode = ~stall.
  - enable_execute = 1.
  - bubble = stall | ~dec_valid.
  - issue = ~bubble.
- ex_load tracking, per edge in RUN:
  - If issue and opcode is LW (100011), LB (100000) or LBU (100100): ex_load_valid<=1, ex_load_rt<=dec_rt.
  - Else: ex_load_valid<=0.
  - Outside RUN: ex_load_valid<=0.
- md_count, per edge:
  - issue & MULT/MULTU -> MULT_LAT.
  - issue & DIV/DIVU -> DIV_LAT.
  - else if md_count!=0 -> md_count-1; saturates at 0.
  - Counts down in every state including IDLE, so an in-flight divide completes across run toggling.
- An MFHI issued right after MULT with MULT_LAT=4 stalls exactly 4 cycles.
- Simultaneous load and md stall: single stall cycle; both flags assert; md_count still decrements.
- Back-to-back mult/div: the second stalls until md_busy=0, then reloads the counter.
- Load followed by a non-dependent instruction: no stall.
- Load with rt=0: no hazard.

Test Plan:
- reset=1 for 2 cycles, then run=1 -> cycle1 fetch only, cycle2 fetch+decode, cycle3 onward all three enables=1 with bubble=0 for valid instructions; all outputs 0 while reset is high.
- LW rt=8 issues, next decode ADD rs=8 -> exactly one cycle with stall_load=1, bubble=1, enable_fetch=0, then issue=1; same with ADD rs=9 -> no stall.
- MULT issues (MULT_LAT=4), next decode MFLO -> stall_md=1 for 4 cycles, md_busy 1->0 as the count goes 4,3,2,1, MFLO issues on the 5th cycle.
- DIV issues (DIV_LAT=32), then 31 independent ADDs -> no stalls; next DIVU -> stalls until md_count=0, then md_count reloads to 32.
- reset asserted while md_count=20 and stall_md=1 -> next cycle state IDLE, md_count=0, all outputs 0.
- run deasserted in RUN -> IDLE next cycle; run reasserted -> FILL1/FILL2 sequence repeats; ex_load_valid=0 so no spurious stall.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Fetch/decode/execute sequencing controller. Brings the pipeline
//            up in stages, detects load-use and HI/LO hazards from the decode
//            fields, inserts execute bubbles, and tracks mult/div busy time.
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       dec_valid,
    input  logic [5:0] dec_opcode,
    input  logic [4:0] dec_rs,
    input  logic [4:0] dec_rt,
    input  logic [5:0] dec_func,
    output logic       enable_fetch,
    output logic       enable_decode,
    output logic       enable_execute,
    output logic       bubble,
    output logic       issue,
    output logic       stall_load,
    output logic       stall_md,
    output logic       md_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_mult_lat = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] c_div_lat  = CNT_W'(DIV_LAT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   md_count_q, md_count_d;
    logic               ex_load_valid_q, ex_load_valid_d;
    logic [4:0]         ex_load_rt_q, ex_load_rt_d;

    logic w_rtype, w_uses_rs, w_uses_rt, w_is_load, w_is_mult, w_is_div;
    logic w_is_md, w_is_hilo, w_stall_load, w_stall_md, w_md_busy;

    // Instruction classification and hazard terms from the decode fields
    always_comb begin
        w_rtype   = (dec_opcode == 6'b000000);
        w_is_hilo = w_rtype && (dec_func == 6'b010000 || dec_func == 6'b010010);
        w_is_mult = w_rtype && (dec_func == 6'b011000 || dec_func == 6'b011001);
        w_is_div  = w_rtype && (dec_func == 6'b011010 || dec_func == 6'b011011);
        w_is_md   = w_is_mult || w_is_div;
        w_is_load = (dec_opcode == 6'b100011) || (dec_opcode == 6'b100000) ||
                    (dec_opcode == 6'b100100);

        // Shifts-by-immediate, HI/LO moves, J/JAL and LUI carry no rs source
        w_uses_rs = (dec_rs != 5'd0) &&
                    !(w_rtype && (dec_func == 6'b000000 || dec_func == 6'b000010 ||
                                  dec_func == 6'b000011 || w_is_hilo)) &&
                    !(dec_opcode == 6'b000010 || dec_opcode == 6'b000011 ||
                      dec_opcode == 6'b001111);

        // rt is a source for most R-types, stores and compare branches
        w_uses_rt = (dec_rt != 5'd0) &&
                    ((w_rtype && !(w_is_hilo || dec_func == 6'b001000 ||
                                   dec_func == 6'b001001)) ||
                     dec_opcode == 6'b101011 || dec_opcode == 6'b101000 ||
                     dec_opcode == 6'b000100 || dec_opcode == 6'b000101);

        w_md_busy    = (md_count_q != '0);
        w_stall_load = dec_valid && ex_load_valid_q &&
                       ((w_uses_rs && dec_rs == ex_load_rt_q) ||
                        (w_uses_rt && dec_rt == ex_load_rt_q));
        w_stall_md   = dec_valid && w_md_busy && (w_is_hilo || w_is_md);
    end

    // Next state and per-state outputs; reset forces every output low
    always_comb begin
        state_d        = state_q;
        enable_fetch   = 1'b0;
        enable_decode  = 1'b0;
        enable_execute = 1'b0;
        bubble         = 1'b0;
        issue          = 1'b0;
        stall_load     = 1'b0;
        stall_md       = 1'b0;
        md_busy        = w_md_busy;

        case (state_q)
            IDLE: begin
                if (run) state_d = FILL1;
            end
            FILL1: begin
                enable_fetch = 1'b1;
                state_d      = run ? FILL2 : IDLE;
            end
            FILL2: begin
                enable_fetch  = 1'b1;
                enable_decode = 1'b1;
                state_d       = run ? RUN : IDLE;
            end
            RUN: begin
                stall_load     = w_stall_load;
                stall_md       = w_stall_md;
                enable_fetch   = !(w_stall_load || w_stall_md);
                enable_decode  = !(w_stall_load || w_stall_md);
                enable_execute = 1'b1;
                bubble         = w_stall_load || w_stall_md || !dec_valid;
                issue          = !(w_stall_load || w_stall_md || !dec_valid);
                if (!run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            enable_fetch   = 1'b0;
            enable_decode  = 1'b0;
            enable_execute = 1'b0;
            bubble         = 1'b0;
            issue          = 1'b0;
            stall_load     = 1'b0;
            stall_md       = 1'b0;
            md_busy        = 1'b0;
        end
    end

    // Load tracking for the execute stage and the HI/LO busy countdown
    always_comb begin
        ex_load_valid_d = 1'b0;
        ex_load_rt_d    = ex_load_rt_q;
        if (issue && w_is_load) begin
            ex_load_valid_d = 1'b1;
            ex_load_rt_d    = dec_rt;
        end

        // Keeps counting in every state so an in-flight divide drains
        md_count_d = md_count_q;
        if (issue && w_is_mult)      md_count_d = c_mult_lat;
        else if (issue && w_is_div)  md_count_d = c_div_lat;
        else if (w_md_busy)          md_count_d = md_count_q - CNT_W'(1);
    end

    // State and tracking registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            md_count_q      <= '0;
            ex_load_valid_q <= 1'b0;
            ex_load_rt_q    <= 5'd0;
        end else begin
            state_q         <= state_d;
            md_count_q      <= md_count_d;
            ex_load_valid_q <= ex_load_valid_d;
            ex_load_rt_q    <= ex_load_rt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Directed self-checking bench for pipe_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    logic       clock = 1'b0;
    logic       reset, run, dec_valid;
    logic [5:0] dec_opcode, dec_func;
    logic [4:0] dec_rs, dec_rt;
    logic       enable_fetch, enable_decode, enable_execute, bubble, issue;
    logic       stall_load, stall_md, md_busy;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;

    // Output vector order: fetch, decode, execute, bubble, issue, stall_load, stall_md, md_busy
    localparam logic [7:0] O_ZERO   = 8'b0000_0000;
    localparam logic [7:0] O_F1     = 8'b1000_0000;
    localparam logic [7:0] O_F2     = 8'b1100_0000;
    localparam logic [7:0] O_ISS    = 8'b1110_1000;
    localparam logic [7:0] O_ISS_B  = 8'b1110_1001;
    localparam logic [7:0] O_NOP    = 8'b1111_0000;
    localparam logic [7:0] O_NOP_B  = 8'b1111_0001;
    localparam logic [7:0] O_SLD    = 8'b0011_0100;
    localparam logic [7:0] O_SLD_B  = 8'b0011_0101;
    localparam logic [7:0] O_SMD    = 8'b0011_0011;
    localparam logic [7:0] O_SBOTH  = 8'b0011_0111;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] F_ADD = 6'b100000, F_MULT = 6'b011000, F_DIV = 6'b011010;
    localparam logic [5:0] F_DIVU = 6'b011011, F_MFHI = 6'b010000, F_MFLO = 6'b010010;

    assign outs = {enable_fetch, enable_decode, enable_execute, bubble, issue,
                   stall_load, stall_md, md_busy};

    pipe_ctrl #(.MULT_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .dec_valid      (dec_valid),
        .dec_opcode     (dec_opcode),
        .dec_rs         (dec_rs),
        .dec_rt         (dec_rt),
        .dec_func       (dec_func),
        .enable_fetch   (enable_fetch),
        .enable_decode  (enable_decode),
        .enable_execute (enable_execute),
        .bubble         (bubble),
        .issue          (issue),
        .stall_load     (stall_load),
        .stall_md       (stall_md),
        .md_busy        (md_busy)
    );

    always #5 clock = ~clock;

    // Move to just after the next rising edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Present decode fields, then let the combinational outputs settle
    task automatic drv(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [5:0] fn);
        dec_valid  = v;
        dec_opcode = op;
        dec_rs     = rs;
        dec_rt     = rt;
        dec_func   = fn;
        #3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b1;
        drv(1'b1, OP_R, 5'd1, 5'd2, F_ADD);
        checks++; if (outs !== O_ZERO) begin errors++; $display("FAIL rst_first: outs=%b expected=%b", outs, O_ZERO); end
        cyc(); drv(1'b1, OP_R, 5'd1, 5'd2, F_ADD);
        checks++; if (outs !== O_ZERO) begin errors++; $display("FAIL rst_hold: outs=%b expected=%b", outs, O_ZERO); end
        cyc(); reset = 1'b0; drv(1'b1, OP_R, 5'd1, 5'd2, F_ADD);
        checks++; if (outs !== O_ZERO) begin errors++; $display("FAIL rst_idle: outs=%b expected=%b", outs, O_ZERO); end
        cyc(); drv(1'b1, OP_R, 5'd1, 5'd2, F_ADD);
        checks++; if (outs !== O_F1) begin errors++; $display("FAIL warm_fill1: outs=%b expected=%b", outs, O_F1); end
        cyc(); drv(1'b1, OP_R, 5'd1, 5'd2, F_ADD);
        checks++; if (outs !== O_F2) begin errors++; $display("FAIL warm_fill2: outs=%b expected=%b", outs, O_F2); end
        cyc(); drv(1'b1, OP_R, 5'd1, 5'd2, F_ADD);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL warm_run: outs=%b expected=%b", outs, O_ISS); end
        cyc(); drv(1'b0, OP_R, 5'd1, 5'd2, F_ADD);
        checks++; if (outs !== O_NOP) begin errors++; $display("FAIL run_invalid: outs=%b expected=%b", outs, O_NOP); end
    endtask

    task automatic test_load_use();
        cyc(); drv(1'b1, OP_LW, 5'd1, 5'd8, 6'd0);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL lu_lw: outs=%b expected=%b", outs, O_ISS); end
        cyc(); drv(1'b1, OP_R, 5'd8, 5'd3, F_ADD);
        checks++; if (outs !== O_SLD) begin errors++; $display("FAIL lu_stall_rs: outs=%b expected=%b", outs, O_SLD); end
        cyc(); drv(1'b1, OP_R, 5'd8, 5'd3, F_ADD);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL lu_release: outs=%b expected=%b", outs, O_ISS); end
        cyc(); drv(1'b1, OP_LW, 5'd1, 5'd8, 6'd0);
        cyc(); drv(1'b1, OP_R, 5'd9, 5'd3, F_ADD);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL lu_indep: outs=%b expected=%b", outs, O_ISS); end
        cyc(); drv(1'b1, OP_LW, 5'd1, 5'd8, 6'd0);
        cyc(); drv(1'b1, OP_SW, 5'd1, 5'd8, 6'd0);
        checks++; if (outs !== O_SLD) begin errors++; $display("FAIL lu_stall_rt: outs=%b expected=%b", outs, O_SLD); end
        cyc(); drv(1'b1, OP_LW, 5'd1, 5'd8, 6'd0);
        cyc(); drv(1'b1, OP_LUI, 5'd8, 5'd4, 6'd0);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL lu_lui_norv: outs=%b expected=%b", outs, O_ISS); end
        cyc(); drv(1'b1, OP_LW, 5'd1, 5'd0, 6'd0);
        cyc(); drv(1'b1, OP_R, 5'd0, 5'd0, F_ADD);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL lu_rt_zero: outs=%b expected=%b", outs, O_ISS); end
    endtask

    task automatic test_mult();
        cyc(); drv(1'b1, OP_R, 5'd1, 5'd2, F_MULT);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL md_mult_issue: outs=%b expected=%b", outs, O_ISS); end
        for (int k = 0; k < 4; k++) begin
            cyc(); drv(1'b1, OP_R, 5'd0, 5'd0, F_MFLO);
            checks++; if (outs !== O_SMD) begin errors++; $display("FAIL md_mflo_stall%0d: outs=%b expected=%b", k, outs, O_SMD); end
        end
        cyc(); drv(1'b1, OP_R, 5'd0, 5'd0, F_MFLO);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL md_mflo_issue: outs=%b expected=%b", outs, O_ISS); end
    endtask

    task automatic test_both();
        cyc(); drv(1'b1, OP_R, 5'd1, 5'd2, F_MULT);
        cyc(); drv(1'b1, OP_LW, 5'd1, 5'd8, 6'd0);
        checks++; if (outs !== O_ISS_B) begin errors++; $display("FAIL both_lw: outs=%b expected=%b", outs, O_ISS_B); end
        cyc(); drv(1'b1, OP_R, 5'd8, 5'd2, F_MULT);
        checks++; if (outs !== O_SBOTH) begin errors++; $display("FAIL both_stall: outs=%b expected=%b", outs, O_SBOTH); end
        for (int k = 0; k < 2; k++) begin
            cyc(); drv(1'b1, OP_R, 5'd8, 5'd2, F_MULT);
            checks++; if (outs !== O_SMD) begin errors++; $display("FAIL both_md%0d: outs=%b expected=%b", k, outs, O_SMD); end
        end
        cyc(); drv(1'b1, OP_R, 5'd8, 5'd2, F_MULT);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL both_reissue: outs=%b expected=%b", outs, O_ISS); end
        for (int k = 0; k < 4; k++) begin
            cyc(); drv(1'b0, OP_R, 5'd0, 5'd0, 6'd0);
            checks++; if (outs !== O_NOP_B) begin errors++; $display("FAIL both_drain%0d: outs=%b expected=%b", k, outs, O_NOP_B); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic done;
        cyc(); drv(1'b1, OP_R, 5'd1, 5'd2, F_DIV);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL b2b_div: outs=%b expected=%b", outs, O_ISS); end
        for (int k = 0; k < 31; k++) begin
            cyc(); drv(1'b1, OP_R, 5'd1, 5'd2, F_ADD);
            checks++; if (outs !== O_ISS_B) begin errors++; $display("FAIL b2b_add%0d: outs=%b expected=%b", k, outs, O_ISS_B); end
        end
        cyc(); drv(1'b1, OP_R, 5'd3, 5'd4, F_DIVU);
        checks++; if (outs !== O_SMD) begin errors++; $display("FAIL b2b_divu_stall: outs=%b expected=%b", outs, O_SMD); end
        cyc(); drv(1'b1, OP_R, 5'd3, 5'd4, F_DIVU);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL b2b_divu_issue: outs=%b expected=%b", outs, O_ISS); end
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            cyc(); drv(1'b1, OP_R, 5'd0, 5'd0, F_MFHI);
            if (outs === O_SMD) n++;
            else done = 1'b1;
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL b2b_reload_len: stalls=%0d expected=32", n); end
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL b2b_mfhi_issue: outs=%b expected=%b", outs, O_ISS); end
    endtask

    task automatic test_reset_mid();
        cyc(); drv(1'b1, OP_R, 5'd1, 5'd2, F_DIV);
        for (int k = 0; k < 12; k++) begin
            cyc(); drv(1'b1, OP_R, 5'd1, 5'd2, F_ADD);
        end
        cyc(); drv(1'b1, OP_R, 5'd0, 5'd0, F_MFHI);
        checks++; if (outs !== O_SMD) begin errors++; $display("FAIL rm_stall: outs=%b expected=%b", outs, O_SMD); end
        reset = 1'b1; #1;
        checks++; if (outs !== O_ZERO) begin errors++; $display("FAIL rm_during: outs=%b expected=%b", outs, O_ZERO); end
        cyc(); reset = 1'b0; drv(1'b1, OP_R, 5'd0, 5'd0, F_MFHI);
        checks++; if (outs !== O_ZERO) begin errors++; $display("FAIL rm_idle: outs=%b expected=%b", outs, O_ZERO); end
        cyc(); drv(1'b1, OP_R, 5'd0, 5'd0, F_MFHI);
        checks++; if (outs !== O_F1) begin errors++; $display("FAIL rm_fill1: outs=%b expected=%b", outs, O_F1); end
        cyc(); drv(1'b1, OP_R, 5'd0, 5'd0, F_MFHI);
        checks++; if (outs !== O_F2) begin errors++; $display("FAIL rm_fill2: outs=%b expected=%b", outs, O_F2); end
        cyc(); drv(1'b1, OP_R, 5'd0, 5'd0, F_MFHI);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL rm_mfhi_free: outs=%b expected=%b", outs, O_ISS); end
    endtask

    task automatic test_run_toggle();
        cyc(); run = 1'b0; drv(1'b1, OP_LW, 5'd1, 5'd8, 6'd0);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL rt_last_run: outs=%b expected=%b", outs, O_ISS); end
        cyc(); run = 1'b1; drv(1'b1, OP_R, 5'd8, 5'd3, F_ADD);
        checks++; if (outs !== O_ZERO) begin errors++; $display("FAIL rt_idle: outs=%b expected=%b", outs, O_ZERO); end
        cyc(); drv(1'b1, OP_R, 5'd8, 5'd3, F_ADD);
        checks++; if (outs !== O_F1) begin errors++; $display("FAIL rt_fill1: outs=%b expected=%b", outs, O_F1); end
        cyc(); drv(1'b1, OP_R, 5'd8, 5'd3, F_ADD);
        checks++; if (outs !== O_F2) begin errors++; $display("FAIL rt_fill2: outs=%b expected=%b", outs, O_F2); end
        cyc(); drv(1'b1, OP_R, 5'd8, 5'd3, F_ADD);
        checks++; if (outs !== O_ISS) begin errors++; $display("FAIL rt_no_spurious: outs=%b expected=%b", outs, O_ISS); end
        // Load stall observed while a divide is not pending
        cyc(); drv(1'b1, OP_LW, 5'd1, 5'd5, 6'd0);
        cyc(); drv(1'b1, OP_R, 5'd2, 5'd5, F_ADD);
        checks++; if (outs !== O_SLD) begin errors++; $display("FAIL rt_load_rt: outs=%b expected=%b", outs, O_SLD); end
        checks++; if (outs === O_SLD_B) begin errors++; $display("FAIL rt_busy_clear: outs=%b expected md_busy=0", outs); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mult();
        test_both();
        test_back_to_back();
        test_reset_mid();
        test_run_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
